// File: rtl/mws_pkg.sv
// Shared types for the memory-write scoreboard: FSM states, fail codes and the
// expectation-table entry, sized to the widest bus the scoreboard supports.
package mws_pkg;

  localparam int MWS_MAX_ADDR_W = 64;
  localparam int MWS_MAX_DATA_W = 64;
  localparam int MWS_MAX_LANES  = MWS_MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } mws_state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

  // Narrower buses are zero-extended into these fields on both the table and
  // the observed side, so the upper bits always compare equal.
  typedef struct packed {
    logic [MWS_MAX_ADDR_W-1:0] addr;
    logic [MWS_MAX_DATA_W-1:0] data;
    logic [MWS_MAX_LANES-1:0]  mask;
  } exp_entry_t;

  function automatic logic [MWS_MAX_DATA_W-1:0] lane_expand(input logic [MWS_MAX_LANES-1:0] mask);
    logic [MWS_MAX_DATA_W-1:0] lanes;
    lanes = '0;
    for (int i = 0; i < MWS_MAX_LANES; i++) lanes[i*8 +: 8] = {8{mask[i]}};
    return lanes;
  endfunction

endpackage

// File: rtl/memwrite_scoreboard_if.sv
// Configuration, observed store bus and result signals of the memory-write
// scoreboard; master drives table/bus, slave is the scoreboard itself.
interface memwrite_scoreboard_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_EXP  = 4
);
  localparam int IDXW = (N_EXP > 1) ? $clog2(N_EXP) : 1;
  localparam int CNTW = IDXW + 1;

  logic              cfg_we;
  logic [IDXW-1:0]   cfg_idx;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic [DATA_W/8-1:0] cfg_mask;
  logic [CNTW-1:0]   cfg_count;
  logic              start;

  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  logic              done;
  logic              pass;
  logic [1:0]        fail_code;
  logic [CNTW-1:0]   matched;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  modport master (
    output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_mask, cfg_count, start,
    output memwrite, dataadr, writedata,
    input  done, pass, fail_code, matched, fail_addr, fail_data
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_mask, cfg_count, start,
    input  memwrite, dataadr, writedata,
    output done, pass, fail_code, matched, fail_addr, fail_data
  );

endinterface

// File: rtl/mws_entry_match.sv
// Combinational compare of one expected store against the observed bus:
// address must be equal and every enabled byte lane of the data must agree.
module mws_entry_match
  import mws_pkg::*;
(
  input  exp_entry_t                entry,
  input  logic [MWS_MAX_ADDR_W-1:0] addr,
  input  logic [MWS_MAX_DATA_W-1:0] data,
  output logic                      hit
);

  assign hit = (addr == entry.addr) &&
               (((data ^ entry.data) & lane_expand(entry.mask)) == '0);

endmodule

// File: rtl/memwrite_scoreboard.sv
// Memory-write scoreboard: matches every observed store against a table of
// expected stores and reports pass, mismatch or timeout with the failing write.
//
//   state | meaning
//   IDLE  | after reset; table writable, bus ignored
//   RUN   | armed; table frozen, stores checked, cycle counter running
//   PASS  | all active entries matched (sticky until start/reset)
//   FAIL  | mismatch or timeout, see fail_code (sticky until start/reset)
module memwrite_scoreboard
  import mws_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_EXP   = 4,
  parameter int TIMEOUT = 1000,
  parameter int ORDERED = 1
) (
  input logic clk,
  input logic reset,
  memwrite_scoreboard_if.slave bus
);

  localparam int IDXW = (N_EXP > 1) ? $clog2(N_EXP) : 1;
  localparam int CNTW = IDXW + 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  exp_entry_t        table_q [N_EXP];
  logic [N_EXP-1:0]  hit_raw;
  logic [N_EXP-1:0]  act_mask;
  logic [N_EXP-1:0]  cand;
  logic [IDXW-1:0]   pick;
  logic [IDXW-1:0]   wr_idx;
  logic              wr_ok;

  mws_state_t        state_q, state_d;
  logic [N_EXP-1:0]  bitmap_q, bitmap_d;
  logic [CNTW-1:0]   matched_q, matched_d;
  logic [CNTW-1:0]   active_q, active_d;
  logic [CNTW-1:0]   count_sat;
  logic [TW-1:0]     cyc_q, cyc_d;
  logic [1:0]        fc_q, fc_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fd_q, fd_d;

  logic [MWS_MAX_ADDR_W-1:0] obs_addr;
  logic [MWS_MAX_DATA_W-1:0] obs_data;

  // Table is writable whenever the checker is not running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_EXP; i++) table_q[i] <= '0;
    end else if (bus.cfg_we && state_q != RUN) begin
      table_q[bus.cfg_idx] <= '{addr: MWS_MAX_ADDR_W'(bus.cfg_addr),
                                data: MWS_MAX_DATA_W'(bus.cfg_data),
                                mask: MWS_MAX_LANES'(bus.cfg_mask)};
    end
  end

  assign obs_addr = MWS_MAX_ADDR_W'(bus.dataadr);
  assign obs_data = MWS_MAX_DATA_W'(bus.writedata);

  for (genvar g = 0; g < N_EXP; g++) begin : g_match
    mws_entry_match u_match (
      .entry (table_q[g]),
      .addr  (obs_addr),
      .data  (obs_data),
      .hit   (hit_raw[g])
    );
  end

  assign count_sat = (bus.cfg_count > CNTW'(N_EXP)) ? CNTW'(N_EXP) : bus.cfg_count;

  // Entry selection: next entry in order, or lowest-index unmatched active hit.
  always_comb begin
    act_mask = '0;
    for (int i = 0; i < N_EXP; i++) act_mask[i] = (CNTW'(i) < active_q);
    cand = hit_raw & ~bitmap_q & act_mask;
    pick = '0;
    for (int i = N_EXP - 1; i >= 0; i--) begin
      if (cand[i]) pick = IDXW'(i);
    end
    if (ORDERED != 0) begin
      wr_idx = matched_q[IDXW-1:0];
      wr_ok  = hit_raw[wr_idx];
    end else begin
      wr_idx = pick;
      wr_ok  = |cand;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitmap_d  = bitmap_q;
    matched_d = matched_q;
    active_d  = active_q;
    cyc_d     = cyc_q;
    fc_d      = fc_q;
    fa_d      = fa_q;
    fd_d      = fd_q;
    if (bus.start) begin
      active_d  = count_sat;
      bitmap_d  = '0;
      matched_d = '0;
      cyc_d     = '0;
      fc_d      = FC_NONE;
      fa_d      = '0;
      fd_d      = '0;
      state_d   = (count_sat == '0) ? PASS : RUN;
    end else if (state_q == RUN) begin
      cyc_d = cyc_q + 1'b1;
      if (bus.memwrite && !wr_ok) begin
        state_d = FAIL;
        fc_d    = FC_MISMATCH;
        fa_d    = bus.dataadr;
        fd_d    = bus.writedata;
      end else begin
        if (bus.memwrite) begin
          bitmap_d  = bitmap_q | (N_EXP'(1) << wr_idx);
          matched_d = matched_q + 1'b1;
        end
        // A completing match wins over a timeout on the same edge.
        if (bus.memwrite && (matched_q + 1'b1) == active_q) begin
          state_d = PASS;
        end else if (cyc_q == TW'(TIMEOUT - 1)) begin
          state_d = FAIL;
          fc_d    = FC_TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bitmap_q  <= '0;
      matched_q <= '0;
      active_q  <= '0;
      cyc_q     <= '0;
      fc_q      <= FC_NONE;
      fa_q      <= '0;
      fd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bitmap_q  <= bitmap_d;
      matched_q <= matched_d;
      active_q  <= active_d;
      cyc_q     <= cyc_d;
      fc_q      <= fc_d;
      fa_q      <= fa_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.done      = (state_q == PASS) || (state_q == FAIL);
  assign bus.pass      = (state_q == PASS);
  assign bus.fail_code = fc_q;
  assign bus.matched   = matched_q;
  assign bus.fail_addr = fa_q;
  assign bus.fail_data = fd_q;

endmodule
